// File: rtl/eight_bit_sr_pkg.sv
// rtl/eight_bit_sr_pkg.sv - mode encoding and default width for the universal shift register
package eight_bit_sr_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  function automatic mode_e to_mode(input logic s1, input logic s0);
    return mode_e'({s1, s0});
  endfunction

endpackage

// File: rtl/eight_bit_sr_usr_next_state.sv
// rtl/eight_bit_sr_usr_next_state.sv - combinational next-value mux for the universal shift register
module usr_next_state
  import eight_bit_sr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  mode_e              mode_i,
  input  logic [WIDTH-1:0]   q_i,
  input  logic [WIDTH-1:0]   p_in_i,
  input  logic               sl_i,
  input  logic               sr_i,
  output logic [WIDTH-1:0]   d_o
);

  // Shifted-out bits are dropped; there is no wrap-around path.
  always_comb begin
    d_o = q_i;
    case (mode_i)
      MODE_HOLD: d_o = q_i;
      MODE_SHR:  d_o = {sr_i, q_i[WIDTH-1:1]};
      MODE_SHL:  d_o = {q_i[WIDTH-2:0], sl_i};
      MODE_LOAD: d_o = p_in_i;
      default:   d_o = q_i;
    endcase
  end

endmodule

// File: rtl/eight_bit_sr.sv
// rtl/eight_bit_sr.sv - 74x194-style universal shift register, reset flop bank
module eight_bit_sr
  import eight_bit_sr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s0,
  input  logic               s1,
  input  logic [WIDTH-1:0]   p_in,
  input  logic               shiftleft_input,
  input  logic               shiftright_input,
  output logic [WIDTH-1:0]   out
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  mode_e            mode;

  assign mode = to_mode(s1, s0);

  usr_next_state #(
    .WIDTH (WIDTH)
  ) u_next (
    .mode_i (mode),
    .q_i    (out_q),
    .p_in_i (p_in),
    .sl_i   (shiftleft_input),
    .sr_i   (shiftright_input),
    .d_o    (out_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_eight_bit_sr.sv
// tb/tb_eight_bit_sr.sv - table-driven self-checking bench for eight_bit_sr
module tb_eight_bit_sr;

  logic       clk;
  logic       rst_n;
  logic       s0;
  logic       s1;
  logic [7:0] p_in;
  logic       shiftleft_input;
  logic       shiftright_input;
  logic [7:0] out;

  int checks;
  int failures;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] p_in;
    logic       sl;
    logic       sr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  eight_bit_sr #(.WIDTH(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s0               (s0),
    .s1               (s1),
    .p_in             (p_in),
    .shiftleft_input  (shiftleft_input),
    .shiftright_input (shiftright_input),
    .out              (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout out=%h", out);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [7:0] exp);
    checks++;
    if (out !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, out, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [7:0] p,
                       input logic sl, input logic sr);
    {s1, s0} = m;
    p_in = p;
    shiftleft_input = sl;
    shiftright_input = sr;
  endtask

  task automatic add(input logic [1:0] m, input logic [7:0] p,
                     input logic sl, input logic sr, input logic [7:0] e);
    vec_t v;
    v.mode = m; v.p_in = p; v.sl = sl; v.sr = sr; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      drive(vecs[i].mode, vecs[i].p_in, vecs[i].sl, vecs[i].sr);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;

    // segment A: vectors 0..16, starting from FF
    add(2'b01, 8'h00, 1'b0, 1'b0, 8'h7F);
    add(2'b01, 8'h00, 1'b0, 1'b0, 8'h3F);
    add(2'b01, 8'h00, 1'b0, 1'b0, 8'h1F);
    add(2'b01, 8'h00, 1'b0, 1'b0, 8'h0F);
    add(2'b10, 8'h00, 1'b1, 1'b0, 8'h1F);
    add(2'b10, 8'h00, 1'b1, 1'b0, 8'h3F);
    add(2'b10, 8'h00, 1'b1, 1'b0, 8'h7F);
    add(2'b10, 8'h00, 1'b1, 1'b0, 8'hFF);
    add(2'b10, 8'h00, 1'b1, 1'b0, 8'hFF);
    add(2'b10, 8'h00, 1'b1, 1'b0, 8'hFF);
    add(2'b10, 8'h00, 1'b1, 1'b0, 8'hFF);
    add(2'b10, 8'h00, 1'b1, 1'b0, 8'hFF);
    add(2'b11, 8'hAA, 1'b0, 1'b0, 8'hAA);
    add(2'b00, 8'h55, 1'b1, 1'b0, 8'hAA);
    add(2'b00, 8'hFF, 1'b0, 1'b1, 8'hAA);
    add(2'b00, 8'h00, 1'b1, 1'b1, 8'hAA);
    add(2'b11, 8'hCC, 1'b1, 1'b1, 8'hCC);
    // segment B: vectors 17..22, mixed serial data
    add(2'b11, 8'h00, 1'b1, 1'b1, 8'h00);
    add(2'b10, 8'hFF, 1'b1, 1'b0, 8'h01);
    add(2'b10, 8'hFF, 1'b0, 1'b1, 8'h02);
    add(2'b10, 8'hFF, 1'b1, 1'b0, 8'h05);
    add(2'b10, 8'hFF, 1'b1, 1'b0, 8'h0B);
    add(2'b01, 8'hFF, 1'b0, 1'b1, 8'h85);

    // reset held with load mode active and clock running
    rst_n = 1'b0;
    drive(2'b11, 8'hFF, 1'b1, 1'b1);
    #1;
    check("reset_initial", 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset_hold%0d", i), 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_load_after_reset", 8'hFF);

    run_vecs(0, 17);

    // async reset between edges during a right shift from CC
    @(negedge clk);
    drive(2'b01, 8'h00, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", 8'h00);
    @(posedge clk);
    #1;
    check("async_reset_held", 8'h00);
    @(negedge clk);
    drive(2'b11, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    run_vecs(17, 23);

    // no combinational path from p_in to out
    @(negedge clk);
    drive(2'b11, 8'h3C, 1'b0, 1'b0);
    #1;
    check("no_comb_path", 8'h85);
    @(posedge clk);
    #1;
    check("load_3c", 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
